// File: rtl/com_fifo_out_path_pkg.sv
// Shared constants, drain state encoding and the CRC-8 helper for the
// UART-to-output byte path.
package com_fifo_out_path_pkg;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  localparam int ERR_OVF  = 0;
  localparam int ERR_LOST = 1;
  localparam int ERR_DIS  = 2;

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_START, D_HOLD} drain_state_e;

  // MSB-first CRC-8; folding the byte in up front is equivalent to bit-serial.
  function automatic logic [7:0] crc8Update(input logic [7:0] crcIn,
                                            input logic [7:0] data);
    logic [7:0] c;
    c = crcIn ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/com_fifo_out_path_mem.sv
// 512 x 8 circular buffer with synchronous read, occupancy counter and a
// one-cycle busy flag after every access.
module byte_fifo_mem
  import com_fifo_out_path_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       pushData,
  input  logic             pop,
  output logic [7:0]       popData,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             busy
);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
    if (pop)  popData    <= mem[rdPtr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else begin
      busy <= push | pop;
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
        count <= count + 1'b1;
      end else if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/com_fifo_out_path.sv
// Receive-side hold register + CRC, FIFO buffering, and a drain FSM that
// hands bytes one at a time to the output stage via out_start/out_finish.
module com_fifo_out_path
  import com_fifo_out_path_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_in,
  input  logic             enable_out,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic [7:0]       crc,
  output logic [3:0]       error,
  output logic             in_finish,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             fifo_busy,
  output logic [7:0]       out_data,
  output logic             out_start,
  input  logic             out_finish,
  output logic             drain_finish
);
  logic         holdFull, holdLast;
  logic [7:0]   holdData;
  logic [2:0]   errBits;
  logic         wrGo, pushGo, popGo;
  logic [7:0]   popData;
  drain_state_e state, stateNext;

  // A full hold register is a pending push and always wins over a pop.
  assign wrGo   = holdFull & ~fifo_busy;
  assign pushGo = wrGo & ~fifo_full;

  byte_fifo_mem uMem (
    .clk      (clk),
    .reset    (reset),
    .push     (pushGo),
    .pushData (holdData),
    .pop      (popGo),
    .popData  (popData),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .busy     (fifo_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      holdFull  <= 1'b0;
      holdLast  <= 1'b0;
      holdData  <= '0;
      crc       <= CRC_INIT;
      errBits   <= '0;
      in_finish <= 1'b0;
    end else begin
      if (wrGo) begin
        holdFull <= 1'b0;
        if (fifo_full) errBits[ERR_OVF] <= 1'b1;
        else           crc <= crc8Update(crc, holdData);
        if (holdLast) in_finish <= 1'b1;
      end
      // Accept and push are exclusive: accept needs an empty hold register.
      if (in_valid) begin
        if (!enable_in)   errBits[ERR_DIS]  <= 1'b1;
        else if (holdFull) errBits[ERR_LOST] <= 1'b1;
        else begin
          holdFull <= 1'b1;
          holdData <= in_data;
          holdLast <= in_last;
          if (in_finish) begin
            in_finish <= 1'b0;
            crc       <= CRC_INIT;
          end
        end
      end
    end
  end

  assign error = {1'b0, errBits};

  always_ff @(posedge clk) begin
    if (reset) state <= D_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      D_IDLE:  if (popGo) stateNext = D_WAIT;
      D_WAIT:  stateNext = D_START;
      D_START: stateNext = D_HOLD;
      D_HOLD:  if (out_finish) stateNext = D_IDLE;
      default: stateNext = D_IDLE;
    endcase
  end

  always_comb begin
    popGo = (state == D_IDLE) & enable_out & ~fifo_empty & ~fifo_busy & ~holdFull;
    out_start    = (state == D_START);
    drain_finish = (state == D_IDLE) & fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (reset)                 out_data <= '0;
    else if (state == D_WAIT)  out_data <= popData;
  end
endmodule

// File: tb/tb_com_fifo_out_path.sv
// Directed bench for com_fifo_out_path: CRC check value, drain order,
// overflow, lost byte, reset in HOLD and pointer wrap.
module tb_com_fifo_out_path;
  logic       clk = 1'b0;
  logic       reset, enable_in, enable_out, in_valid, in_last, out_finish;
  logic [7:0] in_data;
  logic [7:0] crc, out_data;
  logic [3:0] error;
  logic [9:0] fifo_count;
  logic       in_finish, fifo_empty, fifo_full, fifo_busy, out_start, drain_finish;

  int         nTests = 0, nFail = 0;
  int         maxCnt = 0;
  bit         autoFinish = 1'b0, respond = 1'b0;
  logic [7:0] gotQ[$];

  com_fifo_out_path dut (
    .clk(clk), .reset(reset), .enable_in(enable_in), .enable_out(enable_out),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .crc(crc),
    .error(error), .in_finish(in_finish), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_busy(fifo_busy),
    .out_data(out_data), .out_start(out_start), .out_finish(out_finish),
    .drain_finish(drain_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (int'(fifo_count) > maxCnt) maxCnt = int'(fifo_count);
  endtask

  function automatic logic [7:0] refCrc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic sendByte(input logic [7:0] b, input logic last);
    in_data = b; in_last = last; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
  endtask

  function automatic logic [63:0] outVec();
    return 64'({crc, error, in_finish, fifo_count, fifo_empty, fifo_full,
                fifo_busy, out_data, out_start, drain_finish});
  endfunction

  localparam logic [63:0] RST_VEC = 64'({8'h00, 4'h0, 1'b0, 10'd0, 1'b1, 1'b0,
                                         1'b0, 8'h00, 1'b0, 1'b1});

  // Output-stage model: collect each byte on out_start, answer one cycle later.
  initial begin
    out_finish = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_finish = respond;
      respond = 1'b0;
      if (out_start) begin
        gotQ.push_back(out_data);
        respond = autoFinish;
      end
    end
  end

  initial begin
    logic [7:0] m, b;
    int         bad;
    reset = 1'b1; enable_in = 1'b0; enable_out = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    tick(); tick();
    chk("reset_state", outVec(), RST_VEC);
    reset = 1'b0;

    // "123456789" with enable_out low
    enable_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sendByte(8'h31 + 8'(i), i == 8);
      if (i == 7) chk("in_finish_before_last", 64'(in_finish), 64'd0);
    end
    chk("crc_check_value", 64'(crc), 64'hF4);
    chk("count_after_9", 64'(fifo_count), 64'd9);
    chk("in_finish_after_last", 64'(in_finish), 64'd1);
    chk("error_clean", 64'(error), 64'd0);
    chk("no_drain_while_disabled", 64'(gotQ.size()), 64'd0);

    // Drain with immediate out_finish
    autoFinish = 1'b1; enable_out = 1'b1;
    for (int c = 0; c < 200 && !(gotQ.size() == 9 && drain_finish); c++) tick();
    tick(); tick();
    chk("drain_pulses", 64'(gotQ.size()), 64'd9);
    bad = 0;
    for (int i = 0; i < gotQ.size(); i++) if (gotQ[i] !== 8'h31 + 8'(i)) bad++;
    chk("drain_order_errs", 64'(bad), 64'd0);
    chk("drain_finish", 64'(drain_finish), 64'd1);
    chk("count_after_drain", 64'(fifo_count), 64'd0);

    // Fill to 512 and overflow by one
    enable_out = 1'b0; m = 8'h00;
    for (int i = 0; i < 512; i++) begin
      b = 8'(i * 7 + 3);
      sendByte(b, 1'b0);
      m = refCrc(m, b);
    end
    chk("full_flag", 64'(fifo_full), 64'd1);
    chk("count_512", 64'(fifo_count), 64'd512);
    chk("crc_512", 64'(crc), 64'(m));
    chk("in_finish_cleared", 64'(in_finish), 64'd0);
    sendByte(8'hA5, 1'b0);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_count_stays", 64'(fifo_count), 64'd512);
    chk("ovf_crc_unchanged", 64'(crc), 64'(m));

    // Back-to-back strobes: second lost while first is still held
    reset = 1'b1; tick(); reset = 1'b0;
    in_data = 8'h5C; in_valid = 1'b1; tick();
    in_data = 8'hC3; tick();
    in_valid = 1'b0;
    chk("busy_after_push", 64'(fifo_busy), 64'd1);
    tick();
    chk("busy_one_cycle", 64'(fifo_busy), 64'd0);
    chk("lost_error", 64'(error), 64'd2);
    chk("lost_count", 64'(fifo_count), 64'd1);
    chk("lost_crc", 64'(crc), 64'(refCrc(8'h00, 8'h5C)));
    enable_in = 1'b0; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk("disabled_error", 64'(error), 64'd6);
    chk("disabled_count", 64'(fifo_count), 64'd1);

    // Reset while the drain sits in HOLD with 5 bytes still queued
    reset = 1'b1; tick(); reset = 1'b0;
    enable_in = 1'b1; autoFinish = 1'b0; gotQ.delete();
    for (int i = 0; i < 6; i++) sendByte(8'h10 + 8'(i), 1'b0);
    enable_out = 1'b1;
    for (int c = 0; c < 20 && !out_start; c++) tick();
    chk("hold_start_seen", 64'(out_start), 64'd1);
    tick(); tick(); tick();
    chk("hold_count", 64'(fifo_count), 64'd5);
    chk("hold_data", 64'(out_data), 64'h10);
    chk("hold_no_restart", 64'(out_start), 64'd0);
    reset = 1'b1; tick();
    chk("reset_in_hold", outVec(), RST_VEC);
    reset = 1'b0; enable_out = 1'b0; tick();

    // 600 bytes with drain running: wraps both pointers
    reset = 1'b1; tick(); reset = 1'b0;
    gotQ.delete(); autoFinish = 1'b1; enable_out = 1'b1; enable_in = 1'b1; maxCnt = 0;
    for (int i = 0; i < 600; i++) sendByte(8'(i) ^ 8'h5A, 1'b0);
    for (int c = 0; c < 4000 && !(gotQ.size() == 600 && drain_finish); c++) tick();
    tick(); tick();
    chk("wrap_pulses", 64'(gotQ.size()), 64'd600);
    bad = 0;
    for (int i = 0; i < gotQ.size(); i++) if (gotQ[i] !== (8'(i) ^ 8'h5A)) bad++;
    chk("wrap_order_errs", 64'(bad), 64'd0);
    chk("wrap_max_le_512", 64'(maxCnt <= 512), 64'd1);
    chk("wrap_empty", 64'(fifo_empty), 64'd1);
    chk("wrap_error", 64'(error), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/com_fifo_out_path.md
Name: com_fifo_out_path

Overview:
- Byte datapath between the UART receiver and the parallel output link.
- Accepts received bytes, updates a running CRC-8 over them, buffers them in a 512-entry FIFO, and drains them one at a time to the output stage.
- The output stage handshakes with out_start/out_finish.
- Sits between the UART receiver and Out_to_between in the top level.

Parameters:
- DEPTH, 512, FIFO entries.
- ADDR_W, 9, log2(DEPTH).
- CRC_POLY, 8'h07, CRC-8 polynomial, MSB-first.
- CRC_INIT, 8'h00, CRC register value after reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- enable_in  input  1  writer side enabled.
- enable_out  input  1  drain side enabled.
- in_data  input  8  received byte.
- in_valid  input  1  one-cycle strobe, in_data valid.
- in_last  input  1  qualifies in_valid: this byte ends the frame.
- crc  output  8  running CRC-8 of accepted bytes.
- error  output  4  sticky error flags.
- in_finish  output  1  frame fully written.
- fifo_count  output  10  current occupancy, 0..512.
- fifo_empty  output  1  count==0.
- fifo_full  output  1  count==DEPTH.
- fifo_busy  output  1  FIFO memory port occupied this cycle.
- out_data  output  8  byte presented to the output stage.
- out_start  output  1  one-cycle pulse, out_data valid.
- out_finish  input  1  output stage done with the current byte.
- drain_finish  output  1  drain idle and FIFO empty.

Behaviour:
- Reset values: crc=CRC_INIT, error=0, in_finish=0, fifo_count=0, fifo_empty=1, fifo_full=0, fifo_busy=0, out_data=0, out_start=0, drain_finish=1. Pointers are 0, the hold register is empty, and the drain FSM is IDLE.
- Reset mid-operation: aborts everything; the FIFO contents are discarded.
- FIFO storage: circular buffer, wr_ptr/rd_ptr of ADDR_W bits, wrapping 511->0. Occupancy is tracked in a 10-bit counter.
- FIFO read is synchronous: data is valid the cycle after a pop.
- fifo_busy is asserted for exactly the one cycle following any push or pop.
- Arbitration: in a cycle with fifo_busy=0 at most one access occurs. A pending push has priority over a pending pop, so push and pop are never simultaneous.
- Writer, accept: with enable_in=1 and in_valid=1, the byte (and in_last) goes into a 1-byte hold register.
  - If the hold register is already full, the byte is lost and error[1] is set.
  - in_valid while enable_in=0 sets error[2] and the byte is ignored.
- Writer, push: the hold register pushes when full and fifo_busy=0 and the writer wins arbitration.
  - If fifo_full, the byte is dropped, error[0] is set, crc is unchanged and the hold register is cleared.
  - Otherwise the byte is written, count is incremented, and crc is updated the same cycle: crc' = CRC8(crc, byte), 8 shift steps MSB-first, XOR with CRC_POLY when the shifted-out bit is 1.
- in_finish:
  - Set when a held byte flagged in_last leaves the hold register (pushed or dropped).
  - Cleared by the next accepted byte, which also reloads crc to CRC_INIT before that byte is folded in.
- error[3] is reserved, always 0. Error bits clear only on reset.
- Drain FSM:
  - IDLE: if enable_out and !fifo_empty and !fifo_busy and no push pending, pop (rd_ptr++, count--) -> WAIT.
  - WAIT: one cycle; latch the memory output into out_data -> START.
  - START: out_start=1 for one cycle -> HOLD.
  - HOLD: out_data is held; on out_finish=1 -> IDLE.
  - out_finish is ignored in other states.
  - Minimum period is 4 cycles per byte with out_finish returned immediately.
  - enable_out=0 only blocks new pops; a transfer in progress completes.
- drain_finish = (state==IDLE) && fifo_empty.
- fifo_count, fifo_empty and fifo_full update the cycle after the access.

Decomposition:
- Shared package: CRC-8 update function, CRC_POLY/CRC_INIT constants, error-bit index constants (ERR_OVF=0, ERR_LOST=1, ERR_DIS=2), drain state enum.
- One natural sub-module: byte_fifo_mem (storage, pointers, count, busy). The writer and drain logic stay in the top.

Test Plan:
- Push 9 bytes "123456789" (0x31..0x39), last flagged, enable_out=0 -> crc=0xF4, fifo_count=9, in_finish=1 after the 9th push, error=0.
- Then enable_out=1, out_finish returned 1 cycle after each out_start -> out_data sequence 0x31..0x39, 9 out_start pulses, then drain_finish=1, fifo_count=0.
- Fill 512 bytes with enable_out=0, then one more -> fifo_full=1, error[0]=1, count stays 512, crc excludes the 513th byte.
- Two in_valid strobes on back-to-back cycles while a push is pending -> the second byte is lost, error[1]=1.
- Assert reset during HOLD with 5 bytes queued -> next cycle all outputs at reset values, FIFO empty.
- Pointer wrap: push/pop 600 bytes with drain running -> output order preserved across the 511->0 wrap, count never exceeds 512.
